// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO and a programmable baud divider.
// Bytes go out LSB-first; back-to-back frames leave no idle gap on the line.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       uart_rxd_out,
   output logic       busy,
   output logic [4:0] fifo_count
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              line_q, line_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [4:0]        count_q, count_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic              push;
   logic              pop;
   logic              bit_end;

   assign push    = tx_valid && ready_q;
   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      line_d  = line_q;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            line_d = 1'b1;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               state_d = START;
               line_d  = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
               line_d  = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               line_d  = shift_q[1];
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  line_d  = 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit so frames abut.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_q];
                  state_d = START;
                  line_d  = 1'b0;
               end else begin
                  state_d = IDLE;
                  line_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = 1'b1;
         end
      endcase

      wr_d = push ? wr_q + PTR_W'(1) : wr_q;
      rd_d = pop  ? rd_q + PTR_W'(1) : rd_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase

      ready_d = (count_d != DEPTH);
      busy_d  = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_q] <= tx_data;
      end
   end

   assign tx_ready     = ready_q;
   assign uart_rxd_out = line_q;
   assign busy         = busy_q;
   assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Line/status history is logged per cycle and checked against hand-derived frame timing.
module tb_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int          HMAX  = 4096;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready;
   logic       uart_rxd_out;
   logic       busy;
   logic [4:0] fifo_count;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic       line_hist  [HMAX];
   logic       busy_hist  [HMAX];
   logic       ready_hist [HMAX];
   logic [4:0] count_hist [HMAX];

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .uart_rxd_out(uart_rxd_out),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   // Advance one edge; history index cyc holds the values right after edge cyc.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (cyc < HMAX) begin
         line_hist[cyc]  = uart_rxd_out;
         busy_hist[cyc]  = busy;
         ready_hist[cyc] = tx_ready;
         count_hist[cyc] = fifo_count;
      end
   endtask

   // Expected line level for frame position k: 0 start, 1..8 data LSB-first, 9 stop.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic [7:0] t;
      t = b;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return t[k-1];
   endfunction

   // Recover a byte from the logged line, sampling mid-bit of a frame popped at edge st.
   function automatic logic [7:0] decode(input int st);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = line_hist[st + int'(CPB) * (b + 1) + 1];
      return r;
   endfunction

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 600) begin
         tick();
         n++;
      end
      ok = (busy === 1'b0);
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_valid = 1'b1;
      tx_data = 8'h5A;
      repeat (3) tick();
      rst = 1'b0;
      tx_valid = 1'b0;
      n_chk++; if (uart_rxd_out !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b, want 1", uart_rxd_out); end
      n_chk++; if (tx_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_ready: got %b, want 1", tx_ready); end
      n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
      n_chk++; if (fifo_count !== 5'd0)   begin n_fail++; $display("FAIL reset_count: got %0d, want 0", fifo_count); end
      tick();
      n_chk++; if (fifo_count !== 5'd0 || uart_rxd_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_no_latch: count=%0d line=%b, want 0/1", fifo_count, uart_rxd_out);
      end
   endtask

   task automatic test_single();
      int e0;
      int nb;
      logic exp;
      bit ok;
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      tick();
      e0 = cyc;
      tx_valid = 1'b0;
      repeat (45) tick();
      n_chk++; if (count_hist[e0] !== 5'd1)   begin n_fail++; $display("FAIL single_count_push: got %0d, want 1", count_hist[e0]); end
      n_chk++; if (count_hist[e0+1] !== 5'd0) begin n_fail++; $display("FAIL single_count_pop: got %0d, want 0", count_hist[e0+1]); end
      n_chk++; if (line_hist[e0] !== 1'b1)    begin n_fail++; $display("FAIL single_pre_idle: got %b, want 1", line_hist[e0]); end
      for (int k = 1; k <= 40; k++) begin
         exp = frame_bit(8'hA5, (k - 1) / int'(CPB));
         n_chk++;
         if (line_hist[e0+k] !== exp) begin
            n_fail++; $display("FAIL single_line cycle %0d: got %b, want %b", k, line_hist[e0+k], exp);
         end
      end
      n_chk++; if (line_hist[e0+41] !== 1'b1) begin n_fail++; $display("FAIL single_post_idle: got %b, want 1", line_hist[e0+41]); end
      nb = 0;
      for (int k = -1; k <= 45; k++) if (busy_hist[e0+k] === 1'b1) nb++;
      n_chk++; if (nb != 41) begin n_fail++; $display("FAIL single_busy_len: got %0d, want 41", nb); end
      n_chk++; if (busy_hist[e0+40] !== 1'b1 || busy_hist[e0+41] !== 1'b0) begin
         n_fail++; $display("FAIL single_busy_edge: got %b%b, want 10", busy_hist[e0+40], busy_hist[e0+41]);
      end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: busy=%b, want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int e0;
      logic exp;
      bit ok;
      tx_data = 8'h00;
      tx_valid = 1'b1;
      tick();
      e0 = cyc;
      tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      repeat (83) tick();
      n_chk++; if (count_hist[e0+1] !== 5'd1) begin n_fail++; $display("FAIL b2b_pushpop_count: got %0d, want 1", count_hist[e0+1]); end
      for (int k = 1; k <= 80; k++) begin
         exp = frame_bit(((k - 1) / 40 != 0) ? 8'hFF : 8'h00, ((k - 1) % 40) / int'(CPB));
         n_chk++;
         if (line_hist[e0+k] !== exp) begin
            n_fail++; $display("FAIL b2b_line cycle %0d: got %b, want %b", k, line_hist[e0+k], exp);
         end
      end
      n_chk++; if (line_hist[e0+81] !== 1'b1) begin n_fail++; $display("FAIL b2b_post_idle: got %b, want 1", line_hist[e0+81]); end
      n_chk++; if (busy_hist[e0+80] !== 1'b1 || busy_hist[e0+81] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_busy_edge: got %b%b, want 10", busy_hist[e0+80], busy_hist[e0+81]);
      end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: busy=%b, want 0", busy); end
   endtask

   task automatic test_full_fifo();
      int nxt;
      int e0;
      int acc_cyc [1:6];
      logic acc;
      logic [7:0] got;
      bit ok;
      for (int i = 1; i <= 6; i++) acc_cyc[i] = -1;
      nxt = 1;
      tx_data = 8'h01;
      tx_valid = 1'b1;
      for (int i = 0; i < 200 && nxt <= 6; i++) begin
         acc = tx_ready;
         tick();
         if (acc) begin
            acc_cyc[nxt] = cyc;
            nxt++;
            tx_data = 8'(nxt);
         end
      end
      tx_valid = 1'b0;
      e0 = acc_cyc[1];
      n_chk++; if (nxt != 7) begin n_fail++; $display("FAIL full_accept_all: got %0d accepted, want 6", nxt - 1); end
      n_chk++; if (acc_cyc[5] != e0 + 4) begin n_fail++; $display("FAIL full_five_accepted: byte5 at +%0d, want +4", acc_cyc[5] - e0); end
      n_chk++; if (ready_hist[e0+4] !== 1'b0 || count_hist[e0+4] !== 5'(DEPTH)) begin
         n_fail++; $display("FAIL full_state: ready=%b count=%0d, want 0/%0d", ready_hist[e0+4], count_hist[e0+4], DEPTH);
      end
      n_chk++; if (ready_hist[e0+40] !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %b, want 0", ready_hist[e0+40]); end
      n_chk++; if (ready_hist[e0+41] !== 1'b1 || count_hist[e0+41] !== 5'd3) begin
         n_fail++; $display("FAIL full_ready_rise: ready=%b count=%0d, want 1/3", ready_hist[e0+41], count_hist[e0+41]);
      end
      n_chk++; if (acc_cyc[6] <= e0 + 41) begin n_fail++; $display("FAIL full_byte6_held: accepted at +%0d, want > +41", acc_cyc[6] - e0); end
      while (cyc < e0 + 250) tick();
      for (int f = 0; f < 6; f++) begin
         got = decode(e0 + 1 + 40 * f);
         n_chk++;
         if (got !== 8'(f + 1) || line_hist[e0+2+40*f] !== 1'b0 || line_hist[e0+38+40*f] !== 1'b1) begin
            n_fail++; $display("FAIL full_order frame %0d: got %h, want %h", f, got, 8'(f + 1));
         end
      end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL full_timeout: busy=%b, want 0", busy); end
   endtask

   task automatic test_simultaneous();
      int e0;
      logic [7:0] got;
      logic [7:0] exp [3];
      bit ok;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h3C;
      tx_data = 8'h11;
      tx_valid = 1'b1;
      tick();
      e0 = cyc;
      tx_data = 8'h22;
      tick();
      tx_valid = 1'b0;
      while (cyc < e0 + 40) tick();
      tx_data = 8'h3C;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      while (cyc < e0 + 125) tick();
      n_chk++; if (count_hist[e0+40] !== 5'd1 || count_hist[e0+41] !== 5'd1) begin
         n_fail++; $display("FAIL simul_count: got %0d->%0d, want 1->1", count_hist[e0+40], count_hist[e0+41]);
      end
      n_chk++; if (line_hist[e0+41] !== 1'b0) begin n_fail++; $display("FAIL simul_no_gap: got %b, want 0", line_hist[e0+41]); end
      for (int f = 0; f < 3; f++) begin
         got = decode(e0 + 1 + 40 * f);
         n_chk++;
         if (got !== exp[f]) begin n_fail++; $display("FAIL simul_order frame %0d: got %h, want %h", f, got, exp[f]); end
      end
      n_chk++; if (line_hist[e0+121] !== 1'b1 || count_hist[e0+121] !== 5'd0) begin
         n_fail++; $display("FAIL simul_end: line=%b count=%0d, want 1/0", line_hist[e0+121], count_hist[e0+121]);
      end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL simul_timeout: busy=%b, want 0", busy); end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      int bad;
      tx_data = 8'h55;
      tx_valid = 1'b1;
      tick();
      e0 = cyc;
      tx_data = 8'h66;
      tick();
      tx_data = 8'h77;
      tick();
      tx_valid = 1'b0;
      while (cyc < e0 + 17) tick();
      n_chk++; if (uart_rxd_out !== 1'b0 || fifo_count !== 5'd2) begin
         n_fail++; $display("FAIL rstmid_pre: line=%b count=%0d, want 0/2", uart_rxd_out, fifo_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++; if (uart_rxd_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_line: got %b, want 1", uart_rxd_out); end
      n_chk++; if (fifo_count !== 5'd0)   begin n_fail++; $display("FAIL rstmid_count: got %0d, want 0", fifo_count); end
      n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rstmid_busy: got %b, want 0", busy); end
      n_chk++; if (tx_ready !== 1'b1)     begin n_fail++; $display("FAIL rstmid_ready: got %b, want 1", tx_ready); end
      repeat (100) tick();
      bad = 0;
      for (int k = 18; k <= 118; k++) if (line_hist[e0+k] !== 1'b1 || busy_hist[e0+k] !== 1'b0) bad++;
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles, want 0", bad); end
   endtask

   task automatic test_ignored_write();
      int e0;
      int e1;
      int n;
      int bad;
      logic [7:0] got;
      logic [7:0] exp [5];
      exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h30; exp[3] = 8'h40; exp[4] = 8'h50;
      tx_valid = 1'b1;
      tx_data = exp[0];
      tick();
      e0 = cyc;
      for (int i = 1; i < 5; i++) begin
         tx_data = exp[i];
         tick();
      end
      tx_data = 8'hEE;
      n = 0;
      while (tx_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      tx_valid = 1'b0;
      n_chk++; if (ready_hist[e0+4] !== 1'b0) begin n_fail++; $display("FAIL ign_full: ready=%b, want 0", ready_hist[e0+4]); end
      n_chk++; if (cyc != e0 + 41) begin n_fail++; $display("FAIL ign_ready_rise: at +%0d, want +41", cyc - e0); end
      while (cyc < e0 + 215) tick();
      for (int f = 0; f < 5; f++) begin
         got = decode(e0 + 1 + 40 * f);
         n_chk++;
         if (got !== exp[f]) begin n_fail++; $display("FAIL ign_order frame %0d: got %h, want %h", f, got, exp[f]); end
      end
      bad = 0;
      for (int k = 201; k <= 214; k++) if (line_hist[e0+k] !== 1'b1) bad++;
      n_chk++; if (bad != 0 || count_hist[e0+214] !== 5'd0) begin
         n_fail++; $display("FAIL ign_no_ee: %0d low cycles, count=%0d, want 0/0", bad, count_hist[e0+214]);
      end
      tx_data = 8'hEE;
      tx_valid = 1'b1;
      tick();
      e1 = cyc;
      tx_valid = 1'b0;
      repeat (44) tick();
      n_chk++; if (count_hist[e1] !== 5'd1) begin n_fail++; $display("FAIL ign_repush_count: got %0d, want 1", count_hist[e1]); end
      got = decode(e1 + 1);
      n_chk++; if (got !== 8'hEE) begin n_fail++; $display("FAIL ign_repush_data: got %h, want ee", got); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_simultaneous();
      test_reset_mid_frame();
      test_ignored_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
